// File: rtl/cdb_issue_scheduler_pkg.sv
// Shared types and default latencies for the CDB issue scheduler and its reservation register.
package cdb_issue_scheduler_pkg;

    typedef enum logic [1:0] {
        UNIT_INT  = 2'd0,
        UNIT_MULT = 2'd1,
        UNIT_DIV  = 2'd2,
        UNIT_MEM  = 2'd3
    } exec_unit_e;

    typedef struct packed {
        logic       valid;
        exec_unit_e unit;
    } rr_slot_t;

    localparam int INT_LAT_DEF  = 1;
    localparam int MULT_LAT_DEF = 4;
    localparam int DIV_LAT_DEF  = 7;
    localparam int MEM_LAT_DEF  = 4;

    localparam rr_slot_t RR_FREE = '{valid: 1'b0, unit: UNIT_INT};

    // Bit order of the result is {mem,div,mult,int}, matching the unit encoding.
    function automatic logic [3:0] unit_onehot(input rr_slot_t slot);
        unit_onehot = slot.valid ? (4'b0001 << slot.unit) : 4'b0000;
    endfunction

endpackage

// File: rtl/cdb_reservation_register.sv
// CDB reservation shift register: slot i names the bus owner i cycles from now.
module cdb_reservation_register
    import cdb_issue_scheduler_pkg::*;
#(
    parameter int INT_LAT  = INT_LAT_DEF,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int MEM_LAT  = MEM_LAT_DEF,
    parameter int RR_DEPTH = 8
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       book_int,
    input  logic       book_mult,
    input  logic       book_div,
    input  logic       book_mem,
    output logic       free_int,
    output logic       free_mult,
    output logic       free_div,
    output logic       free_mem,
    output logic [3:0] cdb_sel
);

    rr_slot_t rr      [RR_DEPTH];
    rr_slot_t rr_next [RR_DEPTH];

    // A booking lands one slot below its latency because the whole register shifts this cycle.
    always_comb begin
        for (int i = 0; i < RR_DEPTH - 1; i++) begin
            rr_next[i] = rr[i + 1];
        end
        rr_next[RR_DEPTH - 1] = RR_FREE;
        if (book_int)  rr_next[INT_LAT - 1]  = '{valid: 1'b1, unit: UNIT_INT};
        if (book_mult) rr_next[MULT_LAT - 1] = '{valid: 1'b1, unit: UNIT_MULT};
        if (book_div)  rr_next[DIV_LAT - 1]  = '{valid: 1'b1, unit: UNIT_DIV};
        if (book_mem)  rr_next[MEM_LAT - 1]  = '{valid: 1'b1, unit: UNIT_MEM};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RR_DEPTH; i++) begin
                rr[i] <= RR_FREE;
            end
        end else begin
            for (int i = 0; i < RR_DEPTH; i++) begin
                rr[i] <= rr_next[i];
            end
        end
    end

    assign free_int  = !rr[INT_LAT].valid;
    assign free_mult = !rr[MULT_LAT].valid;
    assign free_div  = !rr[DIV_LAT].valid;
    assign free_mem  = !rr[MEM_LAT].valid;

    assign cdb_sel = unit_onehot(rr[0]);

endmodule

// File: rtl/cdb_issue_scheduler.sv
// Issue grant controller for the int/mult/div/mem queues; define CDB_SCHED_PERF_EN for perf counters.
module cdb_issue_scheduler
    import cdb_issue_scheduler_pkg::*;
#(
    parameter int INT_LAT  = INT_LAT_DEF,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int MEM_LAT  = MEM_LAT_DEF,
    parameter int RR_DEPTH = 8
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ready_int,
    input  logic        ready_mult,
    input  logic        ready_div,
    input  logic        ready_mem,
    output logic        issue_int,
    output logic        issue_mult,
    output logic        issue_div,
    output logic        issue_mem,
    output logic [3:0]  cdb_sel,
    output logic        div_busy
`ifdef CDB_SCHED_PERF_EN
    ,
    output logic [31:0] perf_issue_cnt,
    output logic [31:0] perf_slot_conflict_cnt,
    output logic [31:0] perf_div_stall_cnt
`endif
);

    localparam int MAX_LAT_A  = (INT_LAT > MULT_LAT) ? INT_LAT : MULT_LAT;
    localparam int MAX_LAT_B  = (DIV_LAT > MEM_LAT) ? DIV_LAT : MEM_LAT;
    localparam int MAX_LAT    = (MAX_LAT_A > MAX_LAT_B) ? MAX_LAT_A : MAX_LAT_B;
    localparam bit SHARED_LAT = (MULT_LAT == MEM_LAT);
    localparam int DCW        = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;

    if (RR_DEPTH <= MAX_LAT) begin : g_bad_depth
        $error("cdb_issue_scheduler: RR_DEPTH must exceed the largest latency");
    end
    if (INT_LAT < 1 || MULT_LAT < 1 || DIV_LAT < 1 || MEM_LAT < 1) begin : g_bad_lat
        $error("cdb_issue_scheduler: every latency must be at least 1");
    end
    if (INT_LAT == MULT_LAT || INT_LAT == DIV_LAT || INT_LAT == MEM_LAT ||
        MULT_LAT == DIV_LAT || DIV_LAT == MEM_LAT) begin : g_dup_lat
        $error("cdb_issue_scheduler: only mult and mem may share a latency");
    end

    logic           free_int, free_mult, free_div, free_mem;
    logic           elig_int, elig_mult, elig_div, elig_mem;
    logic           contest;
    logic           rr_ptr;
    logic [DCW-1:0] div_cnt;

    cdb_reservation_register #(
        .INT_LAT  (INT_LAT),
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .MEM_LAT  (MEM_LAT),
        .RR_DEPTH (RR_DEPTH)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .book_int  (issue_int),
        .book_mult (issue_mult),
        .book_div  (issue_div),
        .book_mem  (issue_mem),
        .free_int  (free_int),
        .free_mult (free_mult),
        .free_div  (free_div),
        .free_mem  (free_mem),
        .cdb_sel   (cdb_sel)
    );

    assign div_busy  = (div_cnt != '0);
    assign elig_int  = ready_int  && free_int;
    assign elig_mult = ready_mult && free_mult;
    assign elig_div  = ready_div  && free_div && !div_busy;
    assign elig_mem  = ready_mem  && free_mem;
    assign contest   = SHARED_LAT && elig_mult && elig_mem;

    // Grants are forced low while reset is held so no queue releases an entry during reset.
    assign issue_int  = rst && elig_int;
    assign issue_mult = rst && elig_mult && !(contest && rr_ptr);
    assign issue_div  = rst && elig_div;
    assign issue_mem  = rst && elig_mem && !(contest && !rr_ptr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr  <= 1'b0;
            div_cnt <= '0;
        end else begin
            if (contest) begin
                rr_ptr <= ~rr_ptr;
            end
            if (issue_div) begin
                div_cnt <= DCW'(DIV_LAT - 1);
            end else if (div_busy) begin
                div_cnt <= div_cnt - 1'b1;
            end
        end
    end

`ifdef CDB_SCHED_PERF_EN
    logic [2:0] issue_sum;
    logic       slot_conflict;
    logic       div_stall;

    function automatic logic [31:0] sat_add(input logic [31:0] cnt, input logic [2:0] inc);
        logic [32:0] sum;
        sum     = {1'b0, cnt} + {30'd0, inc};
        sat_add = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    assign issue_sum = {2'b00, issue_int} + {2'b00, issue_mult} +
                       {2'b00, issue_div} + {2'b00, issue_mem};
    assign slot_conflict = (ready_int  && !free_int)  || (ready_mult && !free_mult) ||
                           (ready_div  && !free_div)  || (ready_mem  && !free_mem)  ||
                           contest;
    assign div_stall = ready_div && div_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_issue_cnt         <= '0;
            perf_slot_conflict_cnt <= '0;
            perf_div_stall_cnt     <= '0;
        end else begin
            perf_issue_cnt         <= sat_add(perf_issue_cnt, issue_sum);
            perf_slot_conflict_cnt <= sat_add(perf_slot_conflict_cnt, {2'b00, slot_conflict});
            perf_div_stall_cnt     <= sat_add(perf_div_stall_cnt, {2'b00, div_stall});
        end
    end
`endif

endmodule

// File: tb/tb_cdb_issue_scheduler.sv
// Directed self-checking bench for cdb_issue_scheduler at default parameters.
module tb_cdb_issue_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ready_int = 1'b0;
    logic       ready_mult = 1'b0;
    logic       ready_div = 1'b0;
    logic       ready_mem = 1'b0;
    logic       issue_int, issue_mult, issue_div, issue_mem;
    logic [3:0] cdb_sel;
    logic       div_busy;

    int checks = 0;
    int failures = 0;

    cdb_issue_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .ready_int  (ready_int),
        .ready_mult (ready_mult),
        .ready_div  (ready_div),
        .ready_mem  (ready_mem),
        .issue_int  (issue_int),
        .issue_mult (issue_mult),
        .issue_div  (issue_div),
        .issue_mem  (issue_mem),
        .cdb_sel    (cdb_sel),
        .div_busy   (div_busy)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are checked 4 units later.
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b0;
        ready_int = 1'b0;
        ready_mult = 1'b0;
        ready_div = 1'b0;
        ready_mem = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        apply_reset();
        ready_mult = 1'b1;
        ready_div = 1'b1;
        #4;
        checks++;
        if (cdb_sel !== 4'b0000 || div_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_state cdb_sel=%b div_busy=%b required 0000/0", cdb_sel, div_busy);
        end
        checks++;
        if (issue_mult !== 1'b1 || issue_div !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_c0_issue mult=%b div=%b required 1/1", issue_mult, issue_div);
        end
        next_cycle();
        ready_mult = 1'b0;
        ready_div = 1'b0;
        ready_int = 1'b1;
        #4;
        checks++;
        if (issue_int !== 1'b1 || div_busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_c1 issue_int=%b div_busy=%b required 1/1", issue_int, div_busy);
        end
        next_cycle();
        ready_mem = 1'b1;
        #2;
        checks++;
        if (cdb_sel !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL reset_c2_cdb got=%b required=0001", cdb_sel);
        end
        rst = 1'b0;
        #2;
        checks++;
        if ({issue_mem, issue_div, issue_mult, issue_int} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_mid_issue got=%b required=0000",
                     {issue_mem, issue_div, issue_mult, issue_int});
        end
        checks++;
        if (cdb_sel !== 4'b0000 || div_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_state cdb_sel=%b div_busy=%b required 0000/0", cdb_sel, div_busy);
        end
        next_cycle();
        ready_int = 1'b0;
        ready_mem = 1'b0;
        rst = 1'b1;
        for (int c = 3; c <= 5; c++) begin
            #4;
            checks++;
            if (cdb_sel !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL reset_after_cdb c=%0d got=%b required=0000", c, cdb_sel);
            end
            next_cycle();
        end
    endtask

    task automatic test_int_stream;
        logic [3:0] exp_sel;
        apply_reset();
        for (int c = 0; c <= 6; c++) begin
            ready_int = (c <= 3);
            #4;
            exp_sel = (c >= 1 && c <= 4) ? 4'b0001 : 4'b0000;
            checks++;
            if (issue_int !== (c <= 3)) begin
                failures++;
                $display("[TB] FAIL int_stream_issue c=%0d got=%b required=%b", c, issue_int, (c <= 3));
            end
            checks++;
            if (cdb_sel !== exp_sel) begin
                failures++;
                $display("[TB] FAIL int_stream_cdb c=%0d got=%b required=%b", c, cdb_sel, exp_sel);
            end
            next_cycle();
        end
        ready_int = 1'b0;
    endtask

    task automatic test_mult_mem_tie;
        logic [3:0] exp_sel;
        logic [1:0] exp_issue;
        apply_reset();
        for (int c = 0; c <= 15; c++) begin
            ready_mult = (c == 0) || (c == 8) || (c == 9);
            ready_mem  = (c == 0) || (c == 1) || (c == 8);
            #4;
            exp_issue = {(c == 1) || (c == 8), (c == 0) || (c == 9)};
            case (c)
                4:       exp_sel = 4'b0010;
                5:       exp_sel = 4'b1000;
                12:      exp_sel = 4'b1000;
                13:      exp_sel = 4'b0010;
                default: exp_sel = 4'b0000;
            endcase
            checks++;
            if ({issue_mem, issue_mult} !== exp_issue) begin
                failures++;
                $display("[TB] FAIL tie_issue c=%0d mem_mult got=%b required=%b",
                         c, {issue_mem, issue_mult}, exp_issue);
            end
            checks++;
            if (cdb_sel !== exp_sel) begin
                failures++;
                $display("[TB] FAIL tie_cdb c=%0d got=%b required=%b", c, cdb_sel, exp_sel);
            end
            next_cycle();
        end
        ready_mult = 1'b0;
        ready_mem = 1'b0;
    endtask

    task automatic test_div_occupancy;
        logic exp_issue;
        logic exp_busy;
        logic [3:0] exp_sel;
        apply_reset();
        ready_div = 1'b1;
        for (int c = 0; c <= 15; c++) begin
            #4;
            exp_issue = (c % 7 == 0);
            exp_busy  = (c % 7 != 0);
            exp_sel   = (c == 7 || c == 14) ? 4'b0100 : 4'b0000;
            checks++;
            if (issue_div !== exp_issue) begin
                failures++;
                $display("[TB] FAIL div_issue c=%0d got=%b required=%b", c, issue_div, exp_issue);
            end
            checks++;
            if (div_busy !== exp_busy) begin
                failures++;
                $display("[TB] FAIL div_busy c=%0d got=%b required=%b", c, div_busy, exp_busy);
            end
            checks++;
            if (cdb_sel !== exp_sel) begin
                failures++;
                $display("[TB] FAIL div_cdb c=%0d got=%b required=%b", c, cdb_sel, exp_sel);
            end
            next_cycle();
        end
        ready_div = 1'b0;
    endtask

    task automatic test_slot_conflict;
        logic [3:0] exp_sel;
        apply_reset();
        for (int c = 0; c <= 6; c++) begin
            ready_mult = (c == 0);
            ready_int  = (c == 3) || (c == 4);
            #4;
            case (c)
                4:       exp_sel = 4'b0010;
                5:       exp_sel = 4'b0001;
                default: exp_sel = 4'b0000;
            endcase
            checks++;
            if (issue_int !== (c == 4) || issue_mult !== (c == 0)) begin
                failures++;
                $display("[TB] FAIL slot_issue c=%0d int=%b mult=%b required %b/%b",
                         c, issue_int, issue_mult, (c == 4), (c == 0));
            end
            checks++;
            if (cdb_sel !== exp_sel) begin
                failures++;
                $display("[TB] FAIL slot_cdb c=%0d got=%b required=%b", c, cdb_sel, exp_sel);
            end
            next_cycle();
        end
        ready_int = 1'b0;
        ready_mult = 1'b0;
    endtask

    task automatic test_all_four;
        logic [3:0] exp_issue;
        logic [3:0] exp_sel;
        apply_reset();
        for (int c = 0; c <= 8; c++) begin
            ready_int  = (c == 0);
            ready_mult = (c == 0);
            ready_div  = (c == 0);
            ready_mem  = (c <= 1);
            #4;
            case (c)
                0:       exp_issue = 4'b0111;
                1:       exp_issue = 4'b1000;
                default: exp_issue = 4'b0000;
            endcase
            case (c)
                1:       exp_sel = 4'b0001;
                4:       exp_sel = 4'b0010;
                5:       exp_sel = 4'b1000;
                7:       exp_sel = 4'b0100;
                default: exp_sel = 4'b0000;
            endcase
            checks++;
            if ({issue_mem, issue_div, issue_mult, issue_int} !== exp_issue) begin
                failures++;
                $display("[TB] FAIL all4_issue c=%0d got=%b required=%b",
                         c, {issue_mem, issue_div, issue_mult, issue_int}, exp_issue);
            end
            checks++;
            if (cdb_sel !== exp_sel) begin
                failures++;
                $display("[TB] FAIL all4_cdb c=%0d got=%b required=%b", c, cdb_sel, exp_sel);
            end
            checks++;
            if (div_busy !== (c >= 1 && c <= 6)) begin
                failures++;
                $display("[TB] FAIL all4_div_busy c=%0d got=%b required=%b", c, div_busy, (c >= 1 && c <= 6));
            end
            next_cycle();
        end
        ready_mem = 1'b0;
    endtask

    initial begin
        test_reset();
        test_int_stream();
        test_mult_mem_tie();
        test_div_occupancy();
        test_slot_conflict();
        test_all_four();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

endmodule
